// File: rtl/gfx_pkg.sv
// Shared graphics definitions for the sprite blitter: screen/sheet geometry,
// pixel and coordinate types, blitter FSM states and clipping helpers.
package gfx_pkg;

    localparam int FB_W     = 640;
    localparam int FB_H     = 480;
    localparam int FB_AW    = 19;
    localparam int SHEET_W  = 353;
    localparam int SHEET_AW = 14;

    localparam logic signed [11:0] FB_W_S = 12'sd640;
    localparam logic signed [11:0] FB_H_S = 12'sd480;

    typedef logic [3:0]         pix_idx_t;
    typedef logic signed [10:0] scr_coord_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } blit_state_t;

    function automatic logic in_screen(input logic signed [11:0] px,
                                       input logic signed [11:0] py);
        return (px >= 12'sd0) && (px < FB_W_S) && (py >= 12'sd0) && (py < FB_H_S);
    endfunction

    // Only meaningful for on-screen coordinates, so the low 10 bits suffice.
    function automatic logic [FB_AW-1:0] fb_lin(input logic [9:0] px,
                                                 input logic [9:0] py);
        return {9'd0, py} * 19'd640 + {9'd0, px};
    endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// Column/row walker for one blit: produces the sheet ROM address and the
// signed screen destination of the current pixel, plus a last-pixel flag.
module blit_addr_gen
    import gfx_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  advance,
    input  logic [8:0]            src_x,
    input  logic [6:0]            src_y,
    input  logic [6:0]            spr_w,
    input  logic [6:0]            spr_h,
    input  scr_coord_t            dst_x,
    input  scr_coord_t            dst_y,
    output logic [SHEET_AW-1:0]   rom_addr,
    output logic signed [11:0]    px,
    output logic signed [11:0]    py,
    output logic                  last
);

    logic [6:0]  col_q, col_d;
    logic [6:0]  row_q, row_d;
    logic        col_wrap_s;
    logic [17:0] sheet_lin_s;

    assign col_wrap_s  = (col_q == spr_w - 7'd1);
    assign last        = col_wrap_s && (row_q == spr_h - 7'd1);
    assign sheet_lin_s = ({11'd0, src_y} + {11'd0, row_q}) * 18'd353
                       + {9'd0, src_x} + {11'd0, col_q};
    assign rom_addr    = sheet_lin_s[SHEET_AW-1:0];
    assign px          = {dst_x[10], dst_x} + {5'd0, col_q};
    assign py          = {dst_y[10], dst_y} + {5'd0, row_q};

    // Raster-order counter stepping.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            col_d = 7'd0;
            row_d = 7'd0;
        end else if (advance) begin
            if (col_wrap_s) begin
                col_d = 7'd0;
                row_d = row_q + 7'd1;
            end else begin
                col_d = col_q + 7'd1;
            end
        end else begin
            col_d = col_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= 7'd0;
            row_q <= 7'd0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Copies a sprite rectangle from the sheet ROM into the framebuffer, one pixel
// per clock, skipping transparent and off-screen pixels.
module sprite_blitter
    import gfx_pkg::*;
#(
    parameter pix_idx_t TRANSP_IDX = 4'd0
)(
    input  logic                vga_clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [8:0]          src_x,
    input  logic [6:0]          src_y,
    input  logic [6:0]          spr_w,
    input  logic [6:0]          spr_h,
    input  scr_coord_t          dst_x,
    input  scr_coord_t          dst_y,
    output logic                busy,
    output logic                done,
    output logic [SHEET_AW-1:0] rom_addr,
    input  pix_idx_t            rom_q,
    output logic [FB_AW-1:0]    fb_addr,
    output pix_idx_t            fb_data,
    output logic                fb_we
);

    blit_state_t state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [8:0]  src_x_q, src_x_d;
    logic [6:0]  src_y_q, src_y_d;
    logic [6:0]  spr_w_q, spr_w_d;
    logic [6:0]  spr_h_q, spr_h_d;
    scr_coord_t  dst_x_q, dst_x_d;
    scr_coord_t  dst_y_q, dst_y_d;

    logic                s0_valid_q, s0_valid_d;
    logic signed [11:0]  s0_px_q, s0_px_d;
    logic signed [11:0]  s0_py_q, s0_py_d;
    logic                fb_we_q, fb_we_d;
    logic [FB_AW-1:0]    fb_addr_q, fb_addr_d;
    pix_idx_t            fb_data_q, fb_data_d;

    logic               latch_s;
    logic               advance_s;
    logic               last_s;
    logic signed [11:0] ag_px_s;
    logic signed [11:0] ag_py_s;

    blit_addr_gen u_addr_gen (
        .clk      (vga_clk),
        .rst_n    (reset_n),
        .clear    (latch_s),
        .advance  (advance_s),
        .src_x    (src_x_q),
        .src_y    (src_y_q),
        .spr_w    (spr_w_q),
        .spr_h    (spr_h_q),
        .dst_x    (dst_x_q),
        .dst_y    (dst_y_q),
        .rom_addr (rom_addr),
        .px       (ag_px_s),
        .py       (ag_py_s),
        .last     (last_s)
    );

    // Blit sequencing: next state and per-state controls.
    always_comb begin
        state_d    = state_q;
        latch_s    = 1'b0;
        advance_s  = 1'b0;
        s0_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    latch_s = 1'b1;
                    if ((spr_w == 7'd0) || (spr_h == 7'd0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                advance_s  = 1'b1;
                s0_valid_d = 1'b1;
                if (last_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Parameter capture; held for the whole blit so a stray start is harmless.
    always_comb begin
        if (latch_s) begin
            src_x_d = src_x;
            src_y_d = src_y;
            spr_w_d = spr_w;
            spr_h_d = spr_h;
            dst_x_d = dst_x;
            dst_y_d = dst_y;
        end else begin
            src_x_d = src_x_q;
            src_y_d = src_y_q;
            spr_w_d = spr_w_q;
            spr_h_d = spr_h_q;
            dst_x_d = dst_x_q;
            dst_y_d = dst_y_q;
        end
    end

    // Write stage: rom_q arrives alongside the stage-0 destination of the same pixel.
    always_comb begin
        s0_px_d = ag_px_s;
        s0_py_d = ag_py_s;
        fb_we_d = s0_valid_q && (rom_q != TRANSP_IDX) && in_screen(s0_px_q, s0_py_q);
        if (fb_we_d) begin
            fb_addr_d = fb_lin(s0_px_q[9:0], s0_py_q[9:0]);
            fb_data_d = rom_q;
        end else begin
            fb_addr_d = fb_addr_q;
            fb_data_d = fb_data_q;
        end
    end

    // All state and output registers.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            src_x_q    <= 9'd0;
            src_y_q    <= 7'd0;
            spr_w_q    <= 7'd0;
            spr_h_q    <= 7'd0;
            dst_x_q    <= 11'sd0;
            dst_y_q    <= 11'sd0;
            s0_valid_q <= 1'b0;
            s0_px_q    <= 12'sd0;
            s0_py_q    <= 12'sd0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= 19'd0;
            fb_data_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            src_x_q    <= src_x_d;
            src_y_q    <= src_y_d;
            spr_w_q    <= spr_w_d;
            spr_h_q    <= spr_h_d;
            dst_x_q    <= dst_x_d;
            dst_y_q    <= dst_y_d;
            s0_valid_q <= s0_valid_d;
            s0_px_q    <= s0_px_d;
            s0_py_q    <= s0_py_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign fb_we   = fb_we_q;
    assign fb_addr = fb_addr_q;
    assign fb_data = fb_data_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a cycle-offset reference model of the blit
// checked every cycle, plus literal expectations for each scenario.
module tb_sprite_blitter;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [8:0]  src_x;
    logic [6:0]  src_y;
    logic [6:0]  spr_w;
    logic [6:0]  spr_h;
    logic [10:0] dst_x;
    logic [10:0] dst_y;
    logic        busy;
    logic        done;
    logic [13:0] rom_addr;
    logic [3:0]  rom_q;
    logic [18:0] fb_addr;
    logic [3:0]  fb_data;
    logic        fb_we;

    sprite_blitter dut (
        .vga_clk  (vga_clk),
        .reset_n  (reset_n),
        .start    (start),
        .src_x    (src_x),
        .src_y    (src_y),
        .spr_w    (spr_w),
        .spr_h    (spr_h),
        .dst_x    (dst_x),
        .dst_y    (dst_y),
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_we    (fb_we)
    );

    always #5 vga_clk = ~vga_clk;

    logic [3:0] rom_mem [0:16383];
    always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model state: one blit described by its parameters and start cycle.
    bit m_active = 1'b0;
    int m_cs, m_sx, m_sy, m_w, m_h, m_dx, m_dy;

    function automatic int m_addr(input int c, input int r);
        return ((m_sy + r) * 353 + m_sx + c) % 16384;
    endfunction

    typedef struct { int a; int d; } wr_t;
    wr_t wlog[$];
    int  rlog[$];
    int  done_cnt = 0;
    int  done_off = -1;
    int  busy_cnt = 0;

    int  mo_off, mo_n, mo_l, mo_k, mo_c, mo_r, mo_v, mo_px, mo_py;
    bit  mo_we;

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge vga_clk) begin
        if (m_active) begin
            mo_off = cyc - m_cs;
            mo_n   = m_w * m_h;
            mo_l   = (mo_n == 0) ? 1 : mo_n + 2;
            chk("busy", int'(busy), int'(mo_off >= 1 && mo_off <= mo_l));
            chk("done", int'(done), int'(mo_off == mo_l));
            if (mo_off >= 1 && mo_off <= mo_n) begin
                mo_k = mo_off - 1;
                chk("rom_addr", int'(rom_addr), m_addr(mo_k % m_w, mo_k / m_w));
                rlog.push_back(int'(rom_addr));
            end
            mo_we = 1'b0;
            if (mo_off >= 3 && mo_off <= mo_n + 2) begin
                mo_k  = mo_off - 3;
                mo_c  = mo_k % m_w;
                mo_r  = mo_k / m_w;
                mo_v  = int'(rom_mem[m_addr(mo_c, mo_r)]);
                mo_px = m_dx + mo_c;
                mo_py = m_dy + mo_r;
                mo_we = (mo_v != 0) && (mo_px >= 0) && (mo_px < 640) && (mo_py >= 0) && (mo_py < 480);
                if (mo_we) begin
                    chk("fb_addr", int'(fb_addr), mo_py * 640 + mo_px);
                    chk("fb_data", int'(fb_data), mo_v);
                end
            end
            chk("fb_we", int'(fb_we), int'(mo_we));
            if (mo_off == mo_l) m_active = 1'b0;
        end else begin
            chk("idle_busy", int'(busy), 0);
            chk("idle_done", int'(done), 0);
            chk("idle_fb_we", int'(fb_we), 0);
        end
        if (fb_we) wlog.push_back('{int'(fb_addr), int'(fb_data)});
        if (done) begin
            done_cnt++;
            done_off = cyc - m_cs;
        end
        if (busy && !done) busy_cnt++;
    end

    task automatic clear_rom();
        for (int i = 0; i < 16384; i++) rom_mem[i] = 4'd0;
    endtask

    task automatic reset_logs();
        wlog.delete();
        rlog.delete();
        done_cnt = 0;
        done_off = -1;
        busy_cnt = 0;
    endtask

    task automatic launch(input int sx, input int sy, input int w, input int h,
                          input int dx, input int dy);
        @(posedge vga_clk);
        #1;
        src_x = sx[8:0];
        src_y = sy[6:0];
        spr_w = w[6:0];
        spr_h = h[6:0];
        dst_x = dx[10:0];
        dst_y = dy[10:0];
        start = 1'b1;
        m_sx = sx; m_sy = sy; m_w = w; m_h = h; m_dx = dx; m_dy = dy;
        m_cs = cyc;
        m_active = 1'b1;
        @(posedge vga_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (m_active && t < 500) begin
            @(posedge vga_clk);
            t++;
        end
        if (m_active) begin
            chk("timeout_waiting_done", 1, 0);
            m_active = 1'b0;
        end
        repeat (3) @(posedge vga_clk);
    endtask

    int cs_save;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        src_x   = 9'd0;
        src_y   = 7'd0;
        spr_w   = 7'd0;
        spr_h   = 7'd0;
        dst_x   = 11'd0;
        dst_y   = 11'd0;
        clear_rom();
        repeat (3) @(posedge vga_clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fb_we", int'(fb_we), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_fb_addr", int'(fb_addr), 0);
        chk("rst_fb_data", int'(fb_data), 0);
        reset_n = 1'b1;
        repeat (2) @(posedge vga_clk);

        // 2x2 basic copy with one transparent pixel.
        rom_mem[50] = 4'd3; rom_mem[51] = 4'd5; rom_mem[403] = 4'd0; rom_mem[404] = 4'd7;
        reset_logs();
        launch(50, 0, 2, 2, 100, 10);
        wait_idle();
        chk("t1_rom_cnt", rlog.size(), 4);
        if (rlog.size() == 4) begin
            chk("t1_rom0", rlog[0], 50);
            chk("t1_rom1", rlog[1], 51);
            chk("t1_rom2", rlog[2], 403);
            chk("t1_rom3", rlog[3], 404);
        end
        chk("t1_wr_cnt", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("t1_wr0_a", wlog[0].a, 6500); chk("t1_wr0_d", wlog[0].d, 3);
            chk("t1_wr1_a", wlog[1].a, 6501); chk("t1_wr1_d", wlog[1].d, 5);
            chk("t1_wr2_a", wlog[2].a, 7141); chk("t1_wr2_d", wlog[2].d, 7);
        end
        chk("t1_done_off", done_off, 6);
        chk("t1_done_cnt", done_cnt, 1);

        // 4x1 at the right screen edge.
        clear_rom();
        for (int i = 0; i < 4; i++) rom_mem[3530 + i] = 4'd9;
        reset_logs();
        launch(0, 10, 4, 1, 638, 0);
        wait_idle();
        chk("t2_wr_cnt", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("t2_wr0_a", wlog[0].a, 638);
            chk("t2_wr1_a", wlog[1].a, 639);
            chk("t2_wr1_d", wlog[1].d, 9);
        end
        chk("t2_busy_before_done", busy_cnt, 5);
        chk("t2_done_off", done_off, 6);

        // Zero-size sprite.
        reset_logs();
        launch(0, 10, 0, 5, 10, 10);
        wait_idle();
        chk("t3_done_off", done_off, 1);
        chk("t3_wr_cnt", wlog.size(), 0);
        chk("t3_done_cnt", done_cnt, 1);

        // Stray starts mid-blit and during DONE are ignored.
        clear_rom();
        m_sx = 100; m_sy = 20;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                rom_mem[m_addr(c, r)] = 4'(1 + c + 3 * r);
        reset_logs();
        launch(100, 20, 3, 3, 5, 5);
        cs_save = m_cs;
        repeat (3) @(posedge vga_clk);
        #1;
        dst_x = 11'd300;
        dst_y = 11'd300;
        start = 1'b1;
        @(posedge vga_clk);
        #1;
        start = 1'b0;
        while (cyc - cs_save < 11) begin
            @(posedge vga_clk);
            #1;
        end
        start = 1'b1;
        @(posedge vga_clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge vga_clk);
        chk("t4_wr_cnt", wlog.size(), 9);
        if (wlog.size() == 9) begin
            chk("t4_wr0_a", wlog[0].a, 3205); chk("t4_wr0_d", wlog[0].d, 1);
            chk("t4_wr8_a", wlog[8].a, 4487); chk("t4_wr8_d", wlog[8].d, 9);
        end
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_done_off", done_off, 11);

        // Reset during row 1 of an 8x8 blit, then a clean rerun.
        clear_rom();
        m_sx = 200; m_sy = 40;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                rom_mem[m_addr(c, r)] = 4'd6;
        reset_logs();
        launch(200, 40, 8, 8, 20, 20);
        while (cyc - m_cs < 12) begin
            @(posedge vga_clk);
            #1;
        end
        reset_n  = 1'b0;
        m_active = 1'b0;
        #1;
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_fb_we", int'(fb_we), 0);
        chk("t5_rst_done", int'(done), 0);
        repeat (3) @(posedge vga_clk);
        #1;
        reset_n = 1'b1;
        chk("t5_partial_wr_cnt", wlog.size(), 9);
        reset_logs();
        launch(200, 40, 8, 8, 20, 20);
        wait_idle();
        chk("t5_wr_cnt", wlog.size(), 64);
        if (wlog.size() == 64) begin
            chk("t5_wr0_a", wlog[0].a, 12820);
            chk("t5_wr0_d", wlog[0].d, 6);
            chk("t5_wr63_a", wlog[63].a, 17307);
        end
        chk("t5_rom0", (rlog.size() > 0) ? rlog[0] : -1, 14320);
        chk("t5_done_off", done_off, 66);

        // Top-left clipping with negative destination and a wrapped sheet address.
        clear_rom();
        rom_mem[2542] = 4'd4; rom_mem[2543] = 4'd4;
        rom_mem[2895] = 4'd4; rom_mem[2896] = 4'd4;
        reset_logs();
        launch(10, 100, 2, 2, -1, -1);
        wait_idle();
        chk("t6_wr_cnt", wlog.size(), 1);
        if (wlog.size() == 1) begin
            chk("t6_wr0_a", wlog[0].a, 0);
            chk("t6_wr0_d", wlog[0].d, 4);
        end
        chk("t6_done_off", done_off, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Write-side counterpart of the sprite ROM renderers.
- Copies a W x H rectangle from a 4-bit-indexed sprite-sheet ROM into the 4-bit-indexed framebuffer RAM at a screen position, one pixel per clock.
- Skips transparent pixels and pixels clipped by the screen edge.
- Sits between game logic (start/done handshake) and the framebuffer write port; the VGA scan-out path reads the framebuffer.

Parameters:
- SHEET_W, 353, sprite-sheet row pitch in pixels.
- SHEET_AW, 14, sheet ROM address width.
- FB_W, 640, framebuffer width in pixels.
- FB_H, 480, framebuffer height in pixels.
- FB_AW, 19, framebuffer address width.
- TRANSP_IDX, 0, palette index treated as transparent (never written).

Ports:
- vga_clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_x  in  9  sheet column of sprite top-left.
- src_y  in  7  sheet row of sprite top-left.
- spr_w  in  7  sprite width, 0..64.
- spr_h  in  7  sprite height, 0..64.
- dst_x  in  11  signed screen x of top-left.
- dst_y  in  11  signed screen y of top-left.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- rom_addr  out  SHEET_AW  sheet ROM read address.
- rom_q  in  4  ROM data; valid exactly 1 cycle after rom_addr.
- fb_addr  out  FB_AW  framebuffer write address.
- fb_data  out  4  framebuffer write data.
- fb_we  out  1  framebuffer write enable.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, fb_we = 0; rom_addr, fb_addr, fb_data, counters = 0.
- Reset mid-blit aborts immediately. Writes already issued remain; no further writes occur.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 latches all inputs and clears col/row. If spr_w=0 or spr_h=0, go to DONE; otherwise go to RUN.
- start while not in IDLE is ignored; latched parameters stay unchanged.
- RUN, each cycle:
  - rom_addr = (src_y+row)*SHEET_W + src_x + col, computed in ≥16 bits, truncated to SHEET_AW.
  - Issue cycle: the stage-0 register holds col, row, and pixel dest px=dst_x+col, py=dst_y+row (signed 12-bit) for that same pixel.
  - Advance col; at col=spr_w-1, wrap col to 0 and increment row.
  - After issuing (spr_w-1, spr_h-1), go to DRAIN.
- Write stage (one cycle after issue, covering RUN and DRAIN):
  - fb_we = 1 iff rom_q != TRANSP_IDX and 0<=px<FB_W and 0<=py<FB_H.
  - fb_addr = py*FB_W + px; fb_data = rom_q.
  - When fb_we=0, fb_addr and fb_data hold their previous values.
- fb_we is registered, so the framebuffer write lands 2 cycles after the corresponding rom_addr.
- DRAIN: one cycle for the last ROM read to return, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- busy = (state != IDLE).
- Latency from the start cycle to the done pulse: spr_w*spr_h + 2 cycles for a non-zero size; 1 cycle for a zero size.
- Clipping is per pixel. A fully off-screen sprite still runs the full cycle count with no writes.
- Boundaries:
  - px = FB_W-1 is written; px = FB_W is not.
  - Negative dst gives partial left/top clipping.
- Throughput: 1 pixel per clock, no stalls; the framebuffer port must accept a write every cycle.

Decomposition:
- Shared package gfx_pkg holds:
  - FB_W, FB_H, FB_AW, SHEET_W, SHEET_AW;
  - the pixel index typedef (4-bit);
  - a screen coordinate typedef (signed 11-bit);
  - the blitter state enum.
- Sub-module blit_addr_gen: col/row counters plus ROM-address and dest-coordinate generation, with a last-pixel flag.
- The top level holds the FSM, write stage, and clipping.

Test Plan:
- 2x2 sprite, src=(50,0), dst=(100,10), ROM indices 3,5,0,7:
  - rom_addr 50,51,403,404;
  - fb writes (6500,3), (6501,5), (7141,7); no write for index 0;
  - done exactly 6 cycles after start.
- 4x1 sprite at dst_x=638, dst_y=0, all indices 9: writes only to addresses 638 and 639; busy for 5 cycles.
- Zero size (spr_w=0, spr_h=5): done one cycle after start; fb_we never asserted.
- start pulsed again mid-blit with different dst: ignored; all writes use the original dst; single done pulse.
- reset_n low during row 1 of an 8x8 blit: busy, fb_we, done drop to 0 immediately; after release, a new start runs a clean blit from col=0, row=0.
- dst=(-1,-1), 2x2 sprite with all indices 4: a single write to address 0; done after 6 cycles.
